clock_sync_scheduler: RTL and testbench
=======================================

Name: clock_sync_scheduler

Overview:
- Sequences time-sync transactions against the PC104 time-sync block.
- Raises a sync request periodically (every PERIOD_S seconds) or on a manual trigger, then waits for the done impulse under a timeout, retrying on failure.
- Validates the remote time and issues a one-cycle load of that time into the local hr/min/sec counter.
- Sits between the local time counter, the user trigger and the PC104 sync block.

Parameters:
- PERIOD_S, 60, seconds between automatic syncs; 0 disables auto sync.
- TIMEOUT_CYC, 1000, clock cycles to wait for sync_done after request.
- BACKOFF_CYC, 200, clock cycles idle between a timeout and the retry.
- MAX_RETRY, 3, retries after the first attempt before declaring failure.
- DRIFT_TOL, 2, seconds of tolerated drift (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle pulse per local second.
- manual_req  in  1  one-cycle pulse requesting an immediate sync.
- sync_done  in  1  one-cycle done impulse from the sync block.
- remote_hr  in  5  synced remote hour.
- remote_min  in  6  synced remote minute.
- remote_sec  in  6  synced remote second.
- local_hr  in  5  current local hour.
- local_min  in  6  current local minute.
- local_sec  in  6  current local second.
- request  out  1  sync request to the sync block; high for exactly 1 cycle per attempt.
- load  out  1  one-cycle strobe; local counter takes load_hr/min/sec.
- load_hr  out  5  hour to load.
- load_min  out  6  minute to load.
- load_sec  out  6  second to load.
- busy  out  1  high in every state except IDLE and FAIL.
- fail  out  1  sticky; set on retry exhaustion or invalid remote time.
- attempts  out  2  attempts used in the current/last transaction (saturating).

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, period counter 0, retry counter 0.
- Period counter: increments on tick_1hz while IDLE. At PERIOD_S-1 a tick starts a sync and clears the counter. Clears on any transaction start.
- States and transitions:
  - IDLE:
    - manual_req, or period expiry, goes to REQ.
    - manual_req and expiry in the same cycle start one transaction.
    - manual_req while busy is ignored (not queued).
  - REQ: request=1 for one cycle; timeout counter cleared; go to WAIT.
  - WAIT:
    - sync_done goes to CHECK.
    - Timeout counter reaching TIMEOUT_CYC-1 without done: if retries<MAX_RETRY go to BACKOFF with retries+1, else go to FAIL.
    - sync_done in the same cycle as the timeout counts as success.
  - BACKOFF: wait BACKOFF_CYC cycles, then go to REQ.
  - CHECK: remote_hr<24, remote_min<60 and remote_sec<60 goes to LOAD, else go to FAIL. Remote values are sampled in this cycle.
  - LOAD: load=1 for one cycle with the sampled values; fail cleared; go to IDLE.
  - FAIL: fail=1; next cycle go to IDLE. fail stays set until a later transaction reaches LOAD.
- Latency:
  - Request appears 1 cycle after the trigger.
  - Load appears 2 cycles after the sync_done cycle (CHECK, then LOAD).
- sync_done outside WAIT is ignored.
- attempts = 1 on the first request, incremented per retry, saturates at 3.
- Reset asserted mid-transaction aborts it immediately: no load, request low on the next cycle.

Optional Feature:
- Macro: SYNC_DRIFT_CHECK_EN.
- With the macro, CHECK also computes:
  - r = remote seconds-of-day and l = local seconds-of-day, each hr*3600+min*60+sec, 17 bits unsigned.
  - d = |r-l|; drift = min(d, 86400-d), so midnight wrap is handled.
  - If drift <= DRIFT_TOL, go to IDLE without load; fail is cleared.
  - Otherwise go to LOAD.
- Without the macro: every valid remote time is loaded; DRIFT_TOL is unused and the drift logic is absent.

Test Plan:
- PERIOD_S=3, three tick_1hz pulses, sync_done 10 cycles after request, remote 12:34:56 -> one request pulse; load=1 two cycles after done with 12/34/56; attempts=1; busy low afterwards.
- manual_req, no sync_done, TIMEOUT_CYC=1000, MAX_RETRY=3 -> 4 request pulses spaced 1000+200+1 cycles; then fail=1, attempts=3, no load.
- Timeout on the first attempt, sync_done 5 cycles into the second attempt -> load issued, fail cleared, attempts=2.
- sync_done with remote 24:00:00 -> fail=1, no load; a later valid sync clears fail.
- Reset asserted while in WAIT, then sync_done arrives -> no load; next manual_req restarts with attempts=1.
- With SYNC_DRIFT_CHECK_EN and DRIFT_TOL=2:
  - local 23:59:59, remote 00:00:01 -> drift 2, no load.
  - local 10:00:00, remote 10:00:05 -> load with 10/00/05.

Source files
------------

// File: rtl/clock_sync_scheduler_if.sv
// Signal bundle between the time-sync scheduler and its surroundings
// (local time counter, user trigger and PC104 sync block).
interface clock_sync_scheduler_if;
    logic       tick_1hz;
    logic       manual_req;
    logic       sync_done;
    logic [4:0] remote_hr;
    logic [5:0] remote_min;
    logic [5:0] remote_sec;
    logic [4:0] local_hr;
    logic [5:0] local_min;
    logic [5:0] local_sec;
    logic       request;
    logic       load;
    logic [4:0] load_hr;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       busy;
    logic       fail;
    logic [1:0] attempts;
    logic [2:0] fsm_state;

    // Handshake: request is a single-cycle pulse per attempt, with no ready
    // and no hold; sync_done is a single-cycle pulse that only counts while
    // the scheduler waits. load is a single-cycle strobe, and load_* are
    // valid in that cycle.
    modport master (
        input  tick_1hz, manual_req, sync_done,
        input  remote_hr, remote_min, remote_sec,
        input  local_hr, local_min, local_sec,
        output request, load, load_hr, load_min, load_sec,
        output busy, fail, attempts, fsm_state
    );

    modport slave (
        output tick_1hz, manual_req, sync_done,
        output remote_hr, remote_min, remote_sec,
        output local_hr, local_min, local_sec,
        input  request, load, load_hr, load_min, load_sec,
        input  busy, fail, attempts, fsm_state
    );
endinterface

// File: rtl/clock_sync_scheduler.sv
// Periodic/manual time-sync sequencer with timeout, backoff and retry.
// Optional macro SYNC_DRIFT_CHECK_EN skips the load when drift <= DRIFT_TOL.
module clock_sync_scheduler #(
    parameter int PERIOD_S    = 60,
    parameter int TIMEOUT_CYC = 1000,
    parameter int BACKOFF_CYC = 200,
    parameter int MAX_RETRY   = 3,
    parameter int DRIFT_TOL   = 2
) (
    input logic clock,
    input logic reset,
    clock_sync_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_BACKOFF = 3'd3,
        S_CHECK   = 3'd4,
        S_LOAD    = 3'd5,
        S_FAIL    = 3'd6
    } state_t;

    localparam int CNT_MAX = (TIMEOUT_CYC > BACKOFF_CYC) ? TIMEOUT_CYC : BACKOFF_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(PERIOD_S + 2);
    localparam int RW      = $clog2(MAX_RETRY + 2);

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] BACKOFF_LAST = CW'(BACKOFF_CYC - 1);
    localparam logic [PW-1:0] PERIOD_LAST  = (PERIOD_S > 0) ? PW'(PERIOD_S - 1) : '0;
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);
    localparam bit            AUTO_EN      = (PERIOD_S > 0);

    if (PERIOD_S < 0 || TIMEOUT_CYC < 1 || BACKOFF_CYC < 1 || MAX_RETRY < 0 || DRIFT_TOL < 0) begin : g_bad_param
        $error("clock_sync_scheduler: parameter out of range");
    end

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cyc_cnt;
    logic [PW-1:0] period_cnt;
    logic [RW-1:0] retries;
    logic [1:0]    attempts_q;
    logic          fail_q;
    logic [4:0]    load_hr_q;
    logic [5:0]    load_min_q;
    logic [5:0]    load_sec_q;
    logic          period_hit;
    logic          remote_ok;
    logic          skip_load;

    always_comb begin
        period_hit = AUTO_EN && bus.tick_1hz && (period_cnt == PERIOD_LAST);
        remote_ok  = (bus.remote_hr < 5'd24) && (bus.remote_min < 6'd60) && (bus.remote_sec < 6'd60);
    end

`ifdef SYNC_DRIFT_CHECK_EN
    logic [16:0] remote_sod;
    logic [16:0] local_sod;
    logic [16:0] diff;
    logic [16:0] drift;

    // Shortest distance around the 24h circle, so 23:59:59 vs 00:00:01 is 2 s.
    always_comb begin
        remote_sod = 17'(bus.remote_hr) * 17'd3600 + 17'(bus.remote_min) * 17'd60 + 17'(bus.remote_sec);
        local_sod  = 17'(bus.local_hr) * 17'd3600 + 17'(bus.local_min) * 17'd60 + 17'(bus.local_sec);
        diff       = (remote_sod >= local_sod) ? (remote_sod - local_sod) : (local_sod - remote_sod);
        drift      = diff;
        if (diff > 17'd43200 && diff < 17'd86400) begin
            drift = 17'd86400 - diff;
        end
        skip_load  = (drift <= 17'(DRIFT_TOL));
    end
`else
    always_comb begin
        skip_load = 1'b0;
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.manual_req || period_hit) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: state_next = S_WAIT;
            S_WAIT: begin
                if (bus.sync_done) begin
                    state_next = S_CHECK;
                end else if (cyc_cnt == TIMEOUT_LAST) begin
                    state_next = (retries < RETRY_LIMIT) ? S_BACKOFF : S_FAIL;
                end
            end
            S_BACKOFF: begin
                if (cyc_cnt == BACKOFF_LAST) begin
                    state_next = S_REQ;
                end
            end
            S_CHECK: begin
                if (!remote_ok) begin
                    state_next = S_FAIL;
                end else if (skip_load) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD:  state_next = S_IDLE;
            S_FAIL:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cyc_cnt    <= '0;
            period_cnt <= '0;
            retries    <= '0;
            attempts_q <= 2'd0;
            fail_q     <= 1'b0;
            load_hr_q  <= 5'd0;
            load_min_q <= 6'd0;
            load_sec_q <= 6'd0;
        end else begin
            state <= state_next;

            // One counter serves both the WAIT timeout and the BACKOFF delay.
            if (state_next != state) begin
                cyc_cnt <= '0;
            end else if (state == S_WAIT || state == S_BACKOFF) begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end

            if (state == S_IDLE && state_next == S_REQ) begin
                period_cnt <= '0;
            end else if (state == S_IDLE && AUTO_EN && bus.tick_1hz) begin
                period_cnt <= period_cnt + PW'(1);
            end

            if (state == S_IDLE && state_next == S_REQ) begin
                retries <= '0;
            end else if (state == S_WAIT && state_next == S_BACKOFF) begin
                retries <= retries + RW'(1);
            end

            if (state_next == S_REQ) begin
                if (state == S_IDLE) begin
                    attempts_q <= 2'd1;
                end else if (attempts_q != 2'd3) begin
                    attempts_q <= attempts_q + 2'd1;
                end
            end

            if (state_next == S_FAIL) begin
                fail_q <= 1'b1;
            end else if (state_next == S_LOAD || (state == S_CHECK && state_next == S_IDLE)) begin
                fail_q <= 1'b0;
            end

            if (state == S_CHECK) begin
                load_hr_q  <= bus.remote_hr;
                load_min_q <= bus.remote_min;
                load_sec_q <= bus.remote_sec;
            end
        end
    end

    always_comb begin
        bus.request   = (state == S_REQ);
        bus.load      = (state == S_LOAD);
        bus.load_hr   = load_hr_q;
        bus.load_min  = load_min_q;
        bus.load_sec  = load_sec_q;
        bus.busy      = (state != S_IDLE) && (state != S_FAIL);
        bus.fail      = fail_q;
        bus.attempts  = attempts_q;
        bus.fsm_state = state;
    end

endmodule

// File: tb/tb_clock_sync_scheduler.sv
// Self-checking bench for clock_sync_scheduler: periodic, manual, retry,
// invalid-time, reset-abort and (when built with the macro) drift cases.
`timescale 1ns/1ps
module tb_clock_sync_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    clock_sync_scheduler_if bus();

    clock_sync_scheduler #(
        .PERIOD_S(3), .TIMEOUT_CYC(1000), .BACKOFF_CYC(200), .MAX_RETRY(3), .DRIFT_TOL(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [4:0] hr;
        logic [5:0] mn;
        logic [5:0] sc;
        logic       exp_load;
        logic       exp_fail;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int req_cnt = 0;
    int load_cnt = 0;
    int last_req_cyc = 0;
    int last_load_cyc = 0;
    int done_cyc = 0;
    int req_times[$];
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];

    always @(posedge clock) cyc_n <= cyc_n + 1;

    // Monitor: records DUT output events; compared by the main process.
    always @(negedge clock) begin
        if (bus.request === 1'b1) begin
            req_cnt = req_cnt + 1;
            last_req_cyc = cyc_n;
            req_times.push_back(cyc_n);
        end
        if (bus.load === 1'b1) begin
            load_cnt = load_cnt + 1;
            last_load_cyc = cyc_n;
            got_q.push_back({bus.load_hr, bus.load_min, bus.load_sec});
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic drain();
        logic [16:0] g;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_load: got %0h required none", g);
            end else begin
                check("load_value", 32'(g), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic pulse_manual();
        bus.manual_req = 1'b1;
        cyc();
        bus.manual_req = 1'b0;
    endtask

    task automatic pulse_tick();
        bus.tick_1hz = 1'b1;
        cyc();
        bus.tick_1hz = 1'b0;
        cyc(2);
    endtask

    task automatic wait_req(input string name, input int budget);
        int start;
        int n;
        start = req_cnt;
        n = 0;
        while (req_cnt == start && n < budget) begin
            cyc();
            n++;
        end
        check(name, 32'(req_cnt != start), 1);
    endtask

    task automatic send_done(input logic [4:0] hr, input logic [5:0] mn, input logic [5:0] sc,
                             input logic exp_load);
        bus.remote_hr  = hr;
        bus.remote_min = mn;
        bus.remote_sec = sc;
        bus.sync_done  = 1'b1;
        done_cyc = cyc_n;
        if (exp_load) exp_q.push_back({hr, mn, sc});
        cyc();
        bus.sync_done = 1'b0;
    endtask

    task automatic run_txn(input string name, input logic [4:0] hr, input logic [5:0] mn,
                           input logic [5:0] sc, input logic exp_load);
        int base_l;
        base_l = load_cnt;
        pulse_manual();
        wait_req({name, "_req"}, 5);
        cyc(2);
        send_done(hr, mn, sc, exp_load);
        cyc(4);
        drain();
        check({name, "_load_cnt"}, 32'(load_cnt - base_l), 32'(exp_load));
        if (exp_load) check({name, "_load_lat"}, 32'(last_load_cyc), 32'(done_cyc + 2));
    endtask

    vec_t vt[8];
    int   base_r;
    int   base_l;
    int   q0;
    int   tick_cyc;
    int   n;

    initial begin
        vt[0] = '{5'd0,  6'd0,  6'd0,  1'b1, 1'b0};
        vt[1] = '{5'd23, 6'd59, 6'd59, 1'b1, 1'b0};
        vt[2] = '{5'd24, 6'd0,  6'd0,  1'b0, 1'b1};
        vt[3] = '{5'd12, 6'd0,  6'd0,  1'b1, 1'b0};
        vt[4] = '{5'd0,  6'd60, 6'd0,  1'b0, 1'b1};
        vt[5] = '{5'd0,  6'd0,  6'd60, 1'b0, 1'b1};
        vt[6] = '{5'd31, 6'd63, 6'd63, 1'b0, 1'b1};
        vt[7] = '{5'd5,  6'd6,  6'd7,  1'b1, 1'b0};

        bus.tick_1hz = 1'b0;
        bus.manual_req = 1'b0;
        bus.sync_done = 1'b0;
        bus.remote_hr = 5'd0;
        bus.remote_min = 6'd0;
        bus.remote_sec = 6'd0;
        bus.local_hr = 5'd6;
        bus.local_min = 6'd30;
        bus.local_sec = 6'd0;
        reset = 1'b1;
        cyc(3);
        check("reset_outputs", 32'({bus.request, bus.load, bus.busy, bus.fail, bus.attempts,
                                    bus.load_hr, bus.load_min, bus.load_sec}), 0);
        reset = 1'b0;
        cyc(2);

        // Periodic sync on the third tick.
        base_r = req_cnt;
        base_l = load_cnt;
        pulse_tick();
        pulse_tick();
        check("period_no_early_req", 32'(req_cnt - base_r), 0);
        bus.tick_1hz = 1'b1;
        tick_cyc = cyc_n;
        cyc();
        bus.tick_1hz = 1'b0;
        wait_req("period_req", 5);
        check("period_req_latency", 32'(last_req_cyc), 32'(tick_cyc + 1));
        while (cyc_n < last_req_cyc + 10) cyc();
        send_done(5'd12, 6'd34, 6'd56, 1'b1);
        cyc(4);
        drain();
        check("period_load_lat", 32'(last_load_cyc), 32'(done_cyc + 2));
        check("period_req_count", 32'(req_cnt - base_r), 1);
        check("period_load_count", 32'(load_cnt - base_l), 1);
        check("period_attempts", 32'(bus.attempts), 1);
        check("period_busy_after", 32'(bus.busy), 0);

        // No sync_done at all: four attempts, then sticky fail.
        base_r = req_cnt;
        base_l = load_cnt;
        q0 = req_times.size();
        pulse_manual();
        n = 0;
        while (bus.fail !== 1'b1 && n < 6000) begin
            cyc();
            n++;
        end
        check("retry_fail_seen", 32'(bus.fail), 1);
        check("retry_req_count", 32'(req_cnt - base_r), 4);
        for (int i = 1; i < 4; i++) begin
            if (q0 + i < req_times.size())
                check("retry_spacing", 32'(req_times[q0 + i] - req_times[q0 + i - 1]), 1201);
        end
        check("retry_attempts", 32'(bus.attempts), 3);
        check("retry_no_load", 32'(load_cnt - base_l), 0);
        cyc(3);
        check("retry_fail_sticky", 32'(bus.fail), 1);
        check("retry_busy_low", 32'(bus.busy), 0);

        // First attempt times out, second succeeds; manual_req while busy ignored.
        base_r = req_cnt;
        pulse_manual();
        wait_req("second_first_req", 5);
        cyc(3);
        pulse_manual();
        cyc(2);
        check("manual_ignored_busy", 32'(req_cnt - base_r), 1);
        check("busy_in_wait", 32'(bus.busy), 1);
        wait_req("second_retry_req", 1300);
        check("second_spacing", 32'(req_times[req_times.size() - 1] - req_times[req_times.size() - 2]), 1201);
        while (cyc_n < last_req_cyc + 5) cyc();
        send_done(5'd1, 6'd2, 6'd3, 1'b1);
        cyc(4);
        drain();
        check("second_fail_cleared", 32'(bus.fail), 0);
        check("second_attempts", 32'(bus.attempts), 2);

        // Table of remote times: valid ones load, invalid ones fail until a valid one.
        for (int i = 0; i < 8; i++) begin
            run_txn("table", vt[i].hr, vt[i].mn, vt[i].sc, vt[i].exp_load);
            check("table_fail", 32'(bus.fail), 32'(vt[i].exp_fail));
            check("table_attempts", 32'(bus.attempts), 1);
            check("table_busy", 32'(bus.busy), 0);
        end

        // sync_done while idle is ignored.
        base_l = load_cnt;
        send_done(5'd1, 6'd1, 6'd1, 1'b0);
        cyc(4);
        drain();
        check("idle_done_ignored", 32'(load_cnt - base_l), 0);

        // manual_req and period expiry together start a single transaction.
        base_r = req_cnt;
        pulse_tick();
        pulse_tick();
        bus.tick_1hz = 1'b1;
        bus.manual_req = 1'b1;
        cyc();
        bus.tick_1hz = 1'b0;
        bus.manual_req = 1'b0;
        cyc(3);
        check("coincident_one_req", 32'(req_cnt - base_r), 1);
        send_done(5'd2, 6'd2, 6'd2, 1'b1);
        cyc(4);
        drain();
        check("coincident_still_one", 32'(req_cnt - base_r), 1);

        // Period counter was cleared by that start: two ticks are not enough.
        base_r = req_cnt;
        pulse_tick();
        pulse_tick();
        check("period_cleared", 32'(req_cnt - base_r), 0);
        pulse_tick();
        check("period_after_clear", 32'(req_cnt - base_r), 1);
        send_done(5'd3, 6'd4, 6'd5, 1'b1);
        cyc(4);
        drain();

        // Reset in WAIT aborts; a late sync_done loads nothing.
        base_l = load_cnt;
        pulse_manual();
        wait_req("abort_req", 5);
        cyc(3);
        reset = 1'b1;
        cyc();
        check("abort_request_low", 32'(bus.request), 0);
        check("abort_busy_low", 32'(bus.busy), 0);
        check("abort_attempts", 32'(bus.attempts), 0);
        reset = 1'b0;
        send_done(5'd3, 6'd3, 6'd3, 1'b0);
        cyc(4);
        drain();
        check("abort_no_load", 32'(load_cnt - base_l), 0);
        pulse_manual();
        wait_req("restart_req", 5);
        check("restart_attempts", 32'(bus.attempts), 1);
        cyc(2);
        send_done(5'd4, 6'd4, 6'd4, 1'b1);
        cyc(4);
        drain();

        // Drift window across midnight, and a drift beyond tolerance.
        bus.local_hr = 5'd23;
        bus.local_min = 6'd59;
        bus.local_sec = 6'd59;
`ifdef SYNC_DRIFT_CHECK_EN
        run_txn("drift_small", 5'd0, 6'd0, 6'd1, 1'b0);
`else
        run_txn("drift_small", 5'd0, 6'd0, 6'd1, 1'b1);
`endif
        check("drift_small_fail", 32'(bus.fail), 0);
        bus.local_hr = 5'd10;
        bus.local_min = 6'd0;
        bus.local_sec = 6'd0;
        run_txn("drift_large", 5'd10, 6'd0, 6'd5, 1'b1);
        check("drift_large_busy", 32'(bus.busy), 0);

        cyc(5);
        drain();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
